gpio_message_receiver: RTL
==========================

// Module: gpio_message_receiver
// PURPOSE
//  Receive end of the inter-FPGA GPIO message link: deserializes a bit-serial MSG_BITS frame
//  from the peer board's transmitter, raises an ack, and publishes the word on message_in.
//  A byte drain then streams the 16 received characters (first char first) to the LCD writer.
//  Peer GPIO lines are asynchronous to clock and are synchronized internally.
// PARAMETERS
//  MSG_BITS     128  frame length in bits; multiple of CHAR_W
//  CHAR_W       8    character width for the drain port
//  SYNC_STAGES  2    flip-flop stages on each GPIO input (>=2)
// PORTS
//  clock        in   1         system clock, all logic on rising edge
//  RESETN       in   1         asynchronous active-low reset
//  gpio_req     in   1         peer frame-active; high for whole frame
//  gpio_sclk    in   1         peer bit strobe; data valid at its rising edge
//  gpio_data    in   1         serial data, MSB (message_in[MSG_BITS-1]) first
//  gpio_ack     out  1         frame accepted; held until gpio_req falls
//  message_in   out  MSG_BITS  last complete frame
//  msg_valid    out  1         1-cycle pulse when message_in updates
//  frame_err    out  1         1-cycle pulse on aborted frame
//  busy         out  1         high in SHIFT state
//  char_out     out  CHAR_W    current drain character
//  char_valid   out  1         char_out valid
//  char_ready   in   1         consumer accepts char_out when char_valid&char_ready
//  overrun      out  1         sticky: new frame landed while drain unfinished
// BEHAVIOUR
//  - Reset (RESETN=0, any time incl. mid-frame): all outputs 0, message_in=0, state IDLE,
//    bit_cnt=0, drain idle, synchronizers cleared. Partial frame discarded, no frame_err.
//  - req_s/sclk_s/data_s: each input through SYNC_STAGES flops (same depth, so aligned);
//    sclk rising edge = sclk_s & ~sclk_d (one extra flop). Pin edge -> sample: SYNC_STAGES+1 cycles.
//  - FSM IDLE: gpio_ack=0; sclk edges ignored; req_s=1 -> SHIFT, bit_cnt=0, shift reg=0.
//  - SHIFT: busy=1; per sclk edge: shreg <= {shreg[MSG_BITS-2:0], data_s}, bit_cnt++.
//    On edge making bit_cnt==MSG_BITS: next cycle message_in<=shreg incl. that bit,
//    msg_valid=1 for 1 cycle, gpio_ack=1 -> ACK.
//    req_s=0 before MSG_BITS bits: frame_err 1-cycle pulse, message_in unchanged -> IDLE.
//    req_s=0 and final sclk edge in same cycle: edge wins (frame completes).
//  - ACK: gpio_ack=1; extra sclk edges ignored; req_s=0 -> gpio_ack=0 next cycle, IDLE.
//    A new frame needs req low then high again.
//  - Drain: on msg_valid, idx=0, char_valid=1, char_out=message_in[MSG_BITS-1 -: CHAR_W].
//    Each accept (valid&ready): idx++, char_out advances CHAR_W bits; after
//    accept of char MSG_BITS/CHAR_W-1, char_valid=0. char_out stable while stalled.
//  - msg_valid while char_valid=1: overrun<=1 (sticky until reset), drain restarts at idx 0
//    of new message; accept in same cycle is consumed but index still restarts.
//  - bit_cnt width clog2(MSG_BITS+1); no wrap beyond MSG_BITS.
// TESTING
//  1. Frame "hello world!    " (0x68656C6C6F20776F726C642120202020), req high, 128 sclk edges
//     -> message_in matches, one msg_valid pulse, gpio_ack 1 until req drops, then 0.
//  2. req high, 40 sclk edges, req low -> frame_err one pulse, message_in and ack unchanged.
//  3. After test 1, char_ready low 10 cycles then high -> char_out 0x68 held, then
//     0x68,0x65,0x6C.. 16 chars in order, char_valid low after 0x20 #16.
//  4. RESETN low after 70 bits, release, full frame 0xFFFF..FF -> no frame_err, outputs 0 during
//     reset, message_in=all ones, single msg_valid.
//  5. Second frame completes while drain at idx 5 stalled -> overrun=1, char_out = byte 0
//     of new message; overrun stays 1 until reset.
//  6. sclk toggling 20 times with req low, or during ACK -> no state change, message_in unchanged.

Source files
------------

// File: rtl/gpio_message_receiver.sv
// gpio_message_receiver
//   Receive end of the inter-FPGA GPIO message link. A bit-serial frame of
//   MSG_BITS bits (MSB first) is shifted in on rising edges of the peer's
//   strobe while the peer holds gpio_req high. A complete frame is published
//   on message_in with a one-cycle msg_valid pulse, and gpio_ack is raised
//   until the peer drops gpio_req. A byte drain then streams the received
//   characters, first character (most significant) first, to a consumer.
//
// Ports
//   clock, RESETN        system clock (rising edge), async active-low reset
//   gpio_req/sclk/data   asynchronous peer lines, synchronized internally
//   gpio_ack             frame accepted, held until gpio_req falls
//   message_in           last complete frame
//   msg_valid            1-cycle pulse when message_in updates
//   frame_err            1-cycle pulse when gpio_req falls mid-frame
//   busy                 high while shifting a frame
//   char_out/char_valid  drain character and its valid
//   char_ready           consumer accept (char_valid & char_ready)
//   overrun              sticky: a new frame arrived before the drain finished
//   state_dbg            current receive FSM state (IDLE=0, SHIFT=1, ACK=2)
//
// Handshake: a drain character transfers on every rising clock edge where
//   char_valid and char_ready are both high; char_out holds while stalled.
module gpio_message_receiver #(
  parameter int MSG_BITS    = 128,
  parameter int CHAR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clock,
  input  logic                RESETN,
  input  logic                gpio_req,
  input  logic                gpio_sclk,
  input  logic                gpio_data,
  output logic                gpio_ack,
  output logic [MSG_BITS-1:0] message_in,
  output logic                msg_valid,
  output logic                frame_err,
  output logic                busy,
  output logic [CHAR_W-1:0]   char_out,
  output logic                char_valid,
  input  logic                char_ready,
  output logic                overrun,
  output logic [1:0]          state_dbg
);

  localparam int NCHAR = MSG_BITS / CHAR_W;
  localparam int IDX_W = (NCHAR > 1) ? $clog2(NCHAR) : 1;
  localparam int CNT_W = $clog2(MSG_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(MSG_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHAR - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  // Synchronizers: all three lines use the same depth so data stays aligned
  // with the strobe edge it belongs to.
  logic [SYNC_STAGES-1:0] req_sync_q, req_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   sclk_dly_q, sclk_dly_d;
  logic                   req_s, sclk_s, data_s, sclk_rise;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [MSG_BITS-1:0]    shreg_q, shreg_d;
  logic [MSG_BITS-1:0]    message_q, message_d;
  logic                   msg_valid_q, msg_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   gpio_ack_q, gpio_ack_d;

  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   char_valid_q, char_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   accept;
  logic [MSG_BITS-1:0]    char_win;

  always_comb begin
    req_sync_d  = {req_sync_q[SYNC_STAGES-2:0], gpio_req};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], gpio_sclk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], gpio_data};
    req_s       = req_sync_q[SYNC_STAGES-1];
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    data_s      = data_sync_q[SYNC_STAGES-1];
    sclk_dly_d  = sclk_s;
    sclk_rise   = sclk_s & ~sclk_dly_q;
  end

  // Receive FSM. In SHIFT a strobe edge is checked before req_s so the final
  // bit still completes the frame when req falls in the same cycle.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    message_d   = message_q;
    msg_valid_d = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
          shreg_d   = '0;
        end
      end
      ST_SHIFT: begin
        if (sclk_rise) begin
          shreg_d   = {shreg_q[MSG_BITS-2:0], data_s};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            message_d   = shreg_d;
            msg_valid_d = 1'b1;
            state_d     = ST_ACK;
          end
        end else if (!req_s) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (!req_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    gpio_ack_d = (state_d == ST_ACK);
  end

  // Drain. A new message always restarts at character 0; an accept landing
  // in the same cycle is consumed but does not advance the index.
  always_comb begin
    idx_d        = idx_q;
    char_valid_d = char_valid_q;
    overrun_d    = overrun_q;
    accept       = char_valid_q & char_ready;
    if (msg_valid_q) begin
      idx_d        = '0;
      char_valid_d = 1'b1;
      if (char_valid_q) overrun_d = 1'b1;
    end else if (accept) begin
      if (idx_q == LAST_IDX) char_valid_d = 1'b0;
      else                   idx_d        = idx_q + IDX_W'(1);
    end
    char_win = message_q << (int'(idx_q) * CHAR_W);
    char_out = char_win[MSG_BITS-1 -: CHAR_W];
  end

  always_ff @(posedge clock or negedge RESETN) begin
    if (!RESETN) begin
      req_sync_q   <= '0;
      sclk_sync_q  <= '0;
      data_sync_q  <= '0;
      sclk_dly_q   <= 1'b0;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      message_q    <= '0;
      msg_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      gpio_ack_q   <= 1'b0;
      idx_q        <= '0;
      char_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      req_sync_q   <= req_sync_d;
      sclk_sync_q  <= sclk_sync_d;
      data_sync_q  <= data_sync_d;
      sclk_dly_q   <= sclk_dly_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      message_q    <= message_d;
      msg_valid_q  <= msg_valid_d;
      frame_err_q  <= frame_err_d;
      gpio_ack_q   <= gpio_ack_d;
      idx_q        <= idx_d;
      char_valid_q <= char_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign gpio_ack   = gpio_ack_q;
  assign message_in = message_q;
  assign msg_valid  = msg_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q == ST_SHIFT);
  assign char_valid = char_valid_q;
  assign overrun    = overrun_q;
  assign state_dbg  = state_q;

endmodule
